// File: rtl/wb_trace_checker.sv
// Compares writeback register writes against a preloaded expected trace.
// Reports pass, or the first address/data mismatch or inter-write timeout.
module wb_trace_checker #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 256,
  parameter int IGNORE_R0 = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_we,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic [DATA_W-1:0]          ld_mask,
  input  logic                       start,
  input  logic                       wb_we,
  input  logic [ADDR_W-1:0]          wb_waddr,
  input  logic [DATA_W-1:0]          wb_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [DATA_W-1:0]          fail_got,
  output logic [DATA_W-1:0]          fail_exp,
  output logic [$clog2(DEPTH):0]     match_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] C_DATA = 2'b01;
  localparam logic [1:0] C_ADDR = 2'b10;
  localparam logic [1:0] C_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] e_addr [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [DATA_W-1:0] e_mask [DEPTH];

  logic [CW-1:0] count;
  logic [IW-1:0] ptr;
  logic [TW-1:0] timer;

  logic              ld_ok;
  logic [CW-1:0]     cnt_eff;
  logic              qual;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] cur_mask;
  logic              addr_ok;
  logic              data_ok;
  logic              last;
  logic              tmo;

  assign ld_ok   = (state == S_IDLE) && ld_we && (count != FULL);
  assign cnt_eff = count + CW'(ld_ok);
  assign qual    = wb_we && !((IGNORE_R0 != 0) && (wb_waddr == '0));

  assign cur_addr = e_addr[ptr];
  assign cur_data = e_data[ptr];
  assign cur_mask = e_mask[ptr];

  // Masked-off bits drop out before the compare, so X/Z there is harmless.
  assign addr_ok = (wb_waddr == cur_addr);
  assign data_ok = ((wb_wdata & cur_mask) == (cur_data & cur_mask));
  assign last    = (({1'b0, ptr} + CW'(1)) == count);
  assign tmo     = (timer == TLIM);

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      e_addr[count[IW-1:0]] <= ld_addr;
      e_data[count[IW-1:0]] <= ld_data;
      e_mask[count[IW-1:0]] <= ld_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (cnt_eff == '0) ? S_PASS : S_RUN;
      end
      S_RUN: begin
        if (qual) begin
          if (!addr_ok)     state_nx = S_FAIL;
          else if (data_ok) state_nx = last ? S_PASS : S_RUN;
          else              state_nx = S_FAIL;
        end else if (tmo) begin
          state_nx = S_FAIL;
        end
      end
      S_PASS:  state_nx = S_PASS;
      S_FAIL:  state_nx = S_FAIL;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    unique case (state)
      S_RUN:   busy = 1'b1;
      S_PASS:  begin done = 1'b1; pass = 1'b1; end
      S_FAIL:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      ptr       <= '0;
      timer     <= '0;
      match_cnt <= '0;
      fail_code <= '0;
      fail_idx  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          count <= cnt_eff;
          if (start) begin
            ptr       <= '0;
            match_cnt <= '0;
            timer     <= '0;
          end
        end
        S_RUN: begin
          if (qual) begin
            if (!addr_ok) begin
              fail_code <= C_ADDR;
              fail_idx  <= ptr;
              fail_got  <= wb_wdata;
              fail_exp  <= cur_data;
            end else if (data_ok) begin
              ptr       <= ptr + IW'(1);
              match_cnt <= match_cnt + CW'(1);
              timer     <= '0;
            end else begin
              fail_code <= C_DATA;
              fail_idx  <= ptr;
              fail_got  <= wb_wdata;
              fail_exp  <= cur_data;
            end
          end else if (tmo) begin
            fail_code <= C_TMO;
            fail_idx  <= ptr;
            fail_got  <= '0;
            fail_exp  <= cur_data;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker (DEPTH=16, TIMEOUT=8).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_wb_trace_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] ld_mask;
  logic        start;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [3:0]  fail_idx;
  logic [31:0] fail_got;
  logic [31:0] fail_exp;
  logic [4:0]  match_cnt;

  int checks = 0;
  int errors = 0;

  wb_trace_checker #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(16),
    .TIMEOUT(8), .IGNORE_R0(1)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_mask(ld_mask),
    .start(start),
    .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata),
    .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_idx(fail_idx),
    .fail_got(fail_got), .fail_exp(fail_exp),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " pass"}, 64'(pass), 64'd0);
    chk({tag, " code"}, 64'(fail_code), 64'd0);
    chk({tag, " idx"}, 64'(fail_idx), 64'd0);
    chk({tag, " got"}, 64'(fail_got), 64'd0);
    chk({tag, " exp"}, 64'(fail_exp), 64'd0);
    chk({tag, " mcnt"}, 64'(match_cnt), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    chk_idle(tag);
    rst = 1'b1;
    step();
  endtask

  task automatic load(input logic [4:0] a,
                      input logic [31:0] d,
                      input logic [31:0] m);
    ld_we = 1'b1; ld_addr = a;
    ld_data = d; ld_mask = m;
    step();
    ld_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a,
                    input logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    step();
    wb_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ld_we = 1'b0; ld_addr = '0;
    ld_data = '0; ld_mask = '0; start = 1'b0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    #2;
    chk_idle("por");
    rst = 1'b1;
    step();

    // empty trace: start goes straight to pass
    go();
    chk("empty pass", 64'(pass), 64'd1);
    chk("empty busy", 64'(busy), 64'd0);
    do_reset("rst0");

    // three matching writes
    load(5'd1, 32'h0101_0000, 32'hFFFF_FFFF);
    load(5'd1, 32'h0101_0101, 32'hFFFF_FFFF);
    load(5'd2, 32'h0101_1101, 32'hFFFF_FFFF);
    go();
    chk("t36 busy", 64'(busy), 64'd1);
    wb(5'd1, 32'h0101_0000);
    chk("t36 m1", 64'(match_cnt), 64'd1);
    wb(5'd0, 32'hDEAD_BEEF);
    chk("t36 r0", 64'(match_cnt), 64'd1);
    wb(5'd1, 32'h0101_0101);
    chk("t36 pass2", 64'(pass), 64'd0);
    wb(5'd2, 32'h0101_1101);
    chk("t36 pass", 64'(pass), 64'd1);
    chk("t36 done", 64'(done), 64'd1);
    chk("t36 busy0", 64'(busy), 64'd0);
    chk("t36 mcnt", 64'(match_cnt), 64'd3);
    wb(5'd7, 32'h1);
    chk("t36 term", 64'(pass), 64'd1);
    do_reset("rst1");

    // data mismatch
    load(5'd3, 32'h0, 32'hFFFF_FFFF);
    go();
    wb(5'd3, 32'h1);
    chk("t37 code", 64'(fail_code), 64'd1);
    chk("t37 idx", 64'(fail_idx), 64'd0);
    chk("t37 got", 64'(fail_got), 64'h1);
    chk("t37 exp", 64'(fail_exp), 64'h0);
    chk("t37 done", 64'(done), 64'd1);
    chk("t37 pass", 64'(pass), 64'd0);
    wb(5'd3, 32'h5);
    chk("t37 frozen", 64'(fail_got), 64'h1);
    do_reset("rst2");

    // address mismatch at entry 1
    load(5'd2, 32'h22, 32'hFFFF_FFFF);
    load(5'd4, 32'h0000_FF00, 32'hFFFF_FFFF);
    go();
    wb(5'd2, 32'h22);
    wb(5'd1, 32'h0000_FF00);
    chk("t38 code", 64'(fail_code), 64'd2);
    chk("t38 idx", 64'(fail_idx), 64'd1);
    chk("t38 got", 64'(fail_got), 64'h0000_FF00);
    chk("t38 mcnt", 64'(match_cnt), 64'd1);
    do_reset("rst3");

    // masked compare, X on ignored bits
    load(5'd1, 32'hFFFF_00FF, 32'hFFFF_0000);
    load(5'd2, 32'h1234_0000, 32'hFFFF_0000);
    go();
    wb(5'd1, 32'hFFFF_1234);
    chk("t40 m1", 64'(match_cnt), 64'd1);
    wb(5'd2, 32'h1234_xxxx);
    chk("t40 pass", 64'(pass), 64'd1);
    do_reset("rst4");

    // timeout, r0 write does not reset timer
    load(5'd5, 32'hA5A5_0001, 32'hFFFF_FFFF);
    go();
    wb(5'd0, 32'hA5A5_0001);
    repeat (6) step();
    chk("t39 busy7", 64'(busy), 64'd1);
    chk("t39 done7", 64'(done), 64'd0);
    step();
    chk("t39 code", 64'(fail_code), 64'd3);
    chk("t39 done", 64'(done), 64'd1);
    chk("t39 idx", 64'(fail_idx), 64'd0);
    chk("t39 got", 64'(fail_got), 64'd0);
    chk("t39 exp", 64'(fail_exp), 64'hA5A5_0001);
    do_reset("rst5");

    // write in the timeout cycle wins
    load(5'd6, 32'h77, 32'hFFFF_FFFF);
    go();
    repeat (7) step();
    chk("t29 busy", 64'(busy), 64'd1);
    wb(5'd6, 32'h77);
    chk("t29 pass", 64'(pass), 64'd1);
    chk("t29 code", 64'(fail_code), 64'd0);
    do_reset("rst6");

    // start and ld_we in the same cycle
    ld_we = 1'b1; ld_addr = 5'd9;
    ld_data = 32'h99; ld_mask = 32'hFFFF_FFFF;
    start = 1'b1;
    step();
    ld_we = 1'b0; start = 1'b0;
    chk("t23 busy", 64'(busy), 64'd1);
    wb(5'd9, 32'h99);
    chk("t23 pass", 64'(pass), 64'd1);
    do_reset("rst7");

    // async reset mid-run
    load(5'd1, 32'h11, 32'hFFFF_FFFF);
    load(5'd2, 32'h22, 32'hFFFF_FFFF);
    go();
    wb(5'd1, 32'h11);
    chk("t41 m1", 64'(match_cnt), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("t41 async");
    rst = 1'b1;
    step();

    // 17th load is dropped: entry 0 keeps its data
    for (int i = 0; i < 16; i++)
      load(5'(i + 1), 32'h1000 + i, 32'hFFFF_FFFF);
    load(5'd1, 32'hBAD0_0000, 32'hFFFF_FFFF);
    go();
    for (int i = 0; i < 16; i++)
      wb(5'(i + 1), 32'h1000 + i);
    chk("t41 full pass", 64'(pass), 64'd1);
    chk("t41 full mcnt", 64'(match_cnt), 64'd16);
    chk("t41 full code", 64'(fail_code), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
